// File: rtl/chirp_sweep_ctrl.sv
// Burst scheduler for the DDS chirp datapath: emits the per-cycle FTW, phase-clear and
// enable controls for a start/abort-controlled burst of linear chirps with idle gaps.
module chirp_sweep_ctrl #(
    parameter int PHASE_BITS = 32,
    parameter int CNT_BITS   = 24,
    parameter int BURST_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PHASE_BITS-1:0] cfg_f0,
    input  logic [PHASE_BITS-1:0] cfg_step,
    input  logic [CNT_BITS-1:0]   cfg_len,
    input  logic [CNT_BITS-1:0]   cfg_gap,
    input  logic [BURST_BITS-1:0] cfg_count,
    output logic [PHASE_BITS-1:0] ftw,
    output logic                  dds_en,
    output logic                  phase_clr,
    output logic                  chirp_sync,
    output logic [BURST_BITS-1:0] chirp_idx,
    output logic                  busy,
    output logic                  done
);

    // state   | meaning
    // S_IDLE  | waiting for start, all outputs at reset values
    // S_SWEEP | chirp in progress, ftw ramps by step each cycle
    // S_GAP   | idle gap between chirps, dds_en low, ftw parked at f0
    // S_DONE  | one-cycle done pulse after the last chirp of a finite burst
    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_GAP, S_DONE} state_t;

    state_t                state;
    logic [PHASE_BITS-1:0] f0_q;
    logic [PHASE_BITS-1:0] step_q;
    logic [CNT_BITS-1:0]   len_m1_q;
    logic [CNT_BITS-1:0]   gap_q;
    logic [BURST_BITS-1:0] count_q;
    logic [CNT_BITS-1:0]   cnt;
    logic                  last_chirp;
    logic [CNT_BITS-1:0]   cfg_len_m1;

    // A zero length is stored as a one-cycle chirp (terminal count reached immediately).
    assign cfg_len_m1 = (cfg_len == '0) ? '0 : cfg_len - CNT_BITS'(1);
    assign last_chirp = (count_q != '0) && (chirp_idx == count_q - BURST_BITS'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            f0_q       <= '0;
            step_q     <= '0;
            len_m1_q   <= '0;
            gap_q      <= '0;
            count_q    <= '0;
            cnt        <= '0;
            ftw        <= '0;
            dds_en     <= 1'b0;
            phase_clr  <= 1'b0;
            chirp_sync <= 1'b0;
            chirp_idx  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ftw        <= '0;
            dds_en     <= 1'b0;
            phase_clr  <= 1'b0;
            chirp_sync <= 1'b0;
            chirp_idx  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        f0_q       <= cfg_f0;
                        step_q     <= cfg_step;
                        len_m1_q   <= cfg_len_m1;
                        gap_q      <= cfg_gap;
                        count_q    <= cfg_count;
                        cnt        <= cfg_len_m1;
                        state      <= S_SWEEP;
                        ftw        <= cfg_f0;
                        dds_en     <= 1'b1;
                        phase_clr  <= 1'b1;
                        chirp_sync <= 1'b1;
                        chirp_idx  <= '0;
                        busy       <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    phase_clr  <= 1'b0;
                    chirp_sync <= 1'b0;
                    if (cnt == '0) begin
                        if (last_chirp) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            dds_en <= 1'b0;
                            ftw    <= '0;
                        end else if (gap_q != '0) begin
                            state  <= S_GAP;
                            dds_en <= 1'b0;
                            ftw    <= f0_q;
                            cnt    <= gap_q - CNT_BITS'(1);
                        end else begin
                            ftw        <= f0_q;
                            phase_clr  <= 1'b1;
                            chirp_sync <= 1'b1;
                            chirp_idx  <= chirp_idx + BURST_BITS'(1);
                            cnt        <= len_m1_q;
                        end
                    end else begin
                        cnt <= cnt - CNT_BITS'(1);
                        ftw <= ftw + step_q;
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        state      <= S_SWEEP;
                        ftw        <= f0_q;
                        dds_en     <= 1'b1;
                        phase_clr  <= 1'b1;
                        chirp_sync <= 1'b1;
                        chirp_idx  <= chirp_idx + BURST_BITS'(1);
                        cnt        <= len_m1_q;
                    end else begin
                        cnt <= cnt - CNT_BITS'(1);
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    chirp_idx <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chirp_sweep_ctrl.sv
// Scoreboard bench for chirp_sweep_ctrl: a burst-level model expands each request into
// the expected per-cycle output sequence; a negedge monitor pops and compares.
module tb_chirp_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_f0 = '0;
    logic [31:0] cfg_step = '0;
    logic [23:0] cfg_len = '0;
    logic [23:0] cfg_gap = '0;
    logic [7:0]  cfg_count = '0;
    logic [31:0] ftw;
    logic        dds_en;
    logic        phase_clr;
    logic        chirp_sync;
    logic [7:0]  chirp_idx;
    logic        busy;
    logic        done;

    chirp_sweep_ctrl #(.PHASE_BITS(32), .CNT_BITS(24), .BURST_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_f0(cfg_f0), .cfg_step(cfg_step), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
        .cfg_count(cfg_count), .ftw(ftw), .dds_en(dds_en), .phase_clr(phase_clr),
        .chirp_sync(chirp_sync), .chirp_idx(chirp_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // full=0 means ftw and chirp_idx are not defined for that cycle (done cycle).
    typedef struct {
        logic [31:0] ftw;
        logic [7:0]  idx;
        bit          en, clr, sync, busy, done, full;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    function automatic exp_t idle_rec();
        exp_t e;
        e.ftw = '0; e.idx = '0; e.en = 0; e.clr = 0; e.sync = 0;
        e.busy = 0; e.done = 0; e.full = 1;
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            bit   bad;
            e = (sb.size() > 0) ? sb.pop_front() : idle_rec();
            bad = (dds_en !== e.en) || (phase_clr !== e.clr) || (chirp_sync !== e.sync) ||
                  (busy !== e.busy) || (done !== e.done) ||
                  (e.full && ((ftw !== e.ftw) || (chirp_idx !== e.idx)));
            tests++;
            if (bad) begin
                fails++;
                $display("FAIL out_cycle t=%0t got ftw=%h en=%b clr=%b sync=%b idx=%0d busy=%b done=%b required ftw=%h en=%b clr=%b sync=%b idx=%0d busy=%b done=%b full=%b",
                         $time, ftw, dds_en, phase_clr, chirp_sync, chirp_idx, busy, done,
                         e.ftw, e.en, e.clr, e.sync, e.idx, e.busy, e.done, e.full);
            end
        end
    end

    // Expand one burst into cycles: idle (start presented), chirps of max(len,1) cycles
    // with ftw = f0 + i*step, gaps parked at f0, then done; cut after record abort_at.
    task automatic model_burst(input logic [31:0] f0, input logic [31:0] step, input int len,
                               input int gap, input int count, input int abort_at,
                               output int n);
        int   l;
        int   k;
        bit   stop;
        exp_t e;
        l = (len == 0) ? 1 : len;
        k = 0;
        n = 0;
        stop = 0;
        sb.push_back(idle_rec());
        while (!stop) begin
            for (int i = 0; i < l && !stop; i++) begin
                logic [31:0] ii;
                ii = 32'(i);
                e.ftw = f0 + step * ii; e.idx = 8'(k % 256); e.en = 1;
                e.clr = (i == 0); e.sync = (i == 0); e.busy = 1; e.done = 0; e.full = 1;
                sb.push_back(e);
                n++;
                if (abort_at >= 0 && n == abort_at + 1) stop = 1;
            end
            if (!stop && count != 0 && k == count - 1) begin
                e.ftw = '0; e.idx = '0; e.en = 0; e.clr = 0; e.sync = 0;
                e.busy = 1; e.done = 1; e.full = 0;
                sb.push_back(e);
                n++;
                stop = 1;
            end
            for (int g = 0; g < gap && !stop; g++) begin
                e.ftw = f0; e.idx = 8'(k % 256); e.en = 0; e.clr = 0; e.sync = 0;
                e.busy = 1; e.done = 0; e.full = 1;
                sb.push_back(e);
                n++;
                if (abort_at >= 0 && n == abort_at + 1) stop = 1;
            end
            k++;
        end
    endtask

    task automatic wait_drain(input string name);
        int b;
        b = 0;
        while (sb.size() > 0 && b < 5000) begin
            @(posedge clk);
            b++;
        end
        tests++;
        if (sb.size() > 0) begin
            fails++;
            $display("FAIL %s drain: %0d expected cycles left, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Drives one burst request; cfg inputs are scrambled every cycle after acceptance.
    task automatic run_burst(input string name, input logic [31:0] f0, input logic [31:0] step,
                             input int len, input int gap, input int count,
                             input int abort_at, input bit rnd_start);
        int n;
        @(posedge clk); #1;
        cfg_f0 = f0; cfg_step = step; cfg_len = 24'(len); cfg_gap = 24'(gap);
        cfg_count = 8'(count); start = 1'b1; abort = 1'b0;
        model_burst(f0, step, len, gap, count, abort_at, n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
            start     = rnd_start ? ($urandom_range(0, 2) == 0) : 1'b0;
            abort     = (j == abort_at);
            cfg_f0    = $urandom;
            cfg_step  = $urandom;
            cfg_len   = 24'($urandom_range(0, 7));
            cfg_gap   = 24'($urandom_range(0, 3));
            cfg_count = 8'($urandom_range(0, 5));
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        wait_drain(name);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        tests++;
        if (ftw !== '0 || dds_en !== 0 || phase_clr !== 0 || chirp_sync !== 0 ||
            chirp_idx !== '0 || busy !== 0 || done !== 0) begin
            fails++;
            $display("FAIL %s got ftw=%h en=%b clr=%b sync=%b idx=%0d busy=%b done=%b required all zero",
                     name, ftw, dds_en, phase_clr, chirp_sync, chirp_idx, busy, done);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset_state");
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        run_burst("single_chirp", 32'h1000_0000, 32'h0000_0100, 4, 0, 1, -1, 0);
        run_burst("burst_3x", 32'h0200_0000, 32'h0000_0040, 3, 2, 3, -1, 0);
        run_burst("neg_step_wrap", 32'h0000_0010, 32'hFFFF_FFF0, 3, 0, 1, -1, 0);
        run_burst("continuous_abort", 32'h1234_5678, 32'h0000_1000, 2, 0, 0, 600, 0);
        run_burst("len_zero", 32'h0000_0500, 32'h0000_0001, 0, 1, 4, -1, 1);
        run_burst("start_while_busy", 32'hABCD_0000, 32'h0000_0011, 5, 0, 2, -1, 1);
        run_burst("abort_in_gap", 32'h0000_0100, 32'h0000_0002, 2, 3, 3, 3, 0);

        // start together with abort in IDLE must leave the block idle
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL start_and_abort busy=%b required 0", busy);
        end
        repeat (2) @(posedge clk);

        for (int r = 0; r < 40; r++) begin
            int len, gap, count, ab;
            len   = $urandom_range(0, 6);
            gap   = $urandom_range(0, 3);
            count = $urandom_range(1, 4);
            ab    = -1;
            if ($urandom_range(0, 3) == 0)
                ab = $urandom_range(0, count * ((len == 0) ? 1 : len) + (count - 1) * gap);
            run_burst("random_burst", $urandom, $urandom, len, gap, count, ab, 1);
        end

        // asynchronous reset in the middle of a chirp
        mon_en = 1'b0;
        @(posedge clk); #1;
        cfg_f0 = 32'h0000_4000; cfg_step = 32'h10; cfg_len = 24'd50; cfg_gap = 24'd0;
        cfg_count = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b1 || dds_en !== 1'b1) begin
            fails++;
            $display("FAIL mid_sweep_pre_reset busy=%b en=%b required 1 1", busy, dds_en);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset_mid_sweep");
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        mon_en = 1'b1;
        repeat (5) @(posedge clk);

        run_burst("post_reset_burst", 32'h0000_0001, 32'h0000_0001, 2, 1, 2, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/chirp_sweep_ctrl.md
# chirp_sweep_ctrl

Sequencer for the DDS chirp datapath. Generates the per-cycle frequency tuning word (FTW), phase-clear and enable controls that drive the DDS phase accumulator, producing a burst of linear chirps separated by programmable idle gaps. Sits between the register/config interface and the DDS core, replacing the free-running sweep with a start/abort-controlled burst scheduler.

## Interface
Parameters:
- PHASE_BITS, 32, width of FTW, start frequency and step.
- CNT_BITS, 24, width of sweep-length and gap counters.
- BURST_BITS, 8, width of chirp count and index.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a burst; sampled only in IDLE.
- abort  in  1  terminate the burst; honoured in every state.
- cfg_f0  in  PHASE_BITS  start FTW of each chirp.
- cfg_step  in  PHASE_BITS  two's-complement FTW increment per cycle.
- cfg_len  in  CNT_BITS  chirp length in cycles; 0 treated as 1.
- cfg_gap  in  CNT_BITS  idle cycles between chirps; 0 = back-to-back.
- cfg_count  in  BURST_BITS  chirps per burst; 0 = continuous until abort.
- ftw  out  PHASE_BITS  FTW to DDS accumulator.
- dds_en  out  1  DDS accumulator enable.
- phase_clr  out  1  clear DDS phase accumulator this cycle.
- chirp_sync  out  1  one-cycle pulse on first cycle of each chirp.
- chirp_idx  out  BURST_BITS  index of current chirp, 0-based.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a finite burst completes normally.

## Operation
- States: IDLE, SWEEP, GAP, DONE.
- All cfg_* latched into shadow registers on the cycle start is accepted; later cfg changes have no effect until the next burst.
- IDLE: start=1 and abort=0 -> SWEEP. All outputs at reset values.
- SWEEP: first cycle ftw=f0, phase_clr=1, chirp_sync=1, dds_en=1; each later cycle ftw <= ftw + step, mod 2^PHASE_BITS (wraps silently, no saturation). Length counter counts len cycles (min 1).
- End of SWEEP: if this was the last chirp (chirp_idx == count-1, count != 0) -> DONE; else if gap != 0 -> GAP; else -> SWEEP directly with chirp_idx+1 (new chirp_sync/phase_clr, ftw reloaded to f0).
- GAP: dds_en=0, ftw held at f0, runs gap cycles, then -> SWEEP with chirp_idx+1.
- chirp_idx wraps to 0 after 2^BURST_BITS-1 in continuous mode.
- DONE: done=1 for one cycle, busy=1, dds_en=0, then -> IDLE.
- abort=1 in any state -> IDLE next cycle; done not asserted; abort wins over simultaneous start.
- start while busy is ignored (not queued).

## Timing
- Reset values: ftw=0, dds_en=0, phase_clr=0, chirp_sync=0, chirp_idx=0, busy=0, done=0, state IDLE.
- All outputs registered. start at edge N -> first SWEEP cycle outputs visible after edge N+1.
- Chirp occupies exactly max(len,1) cycles of dds_en=1; gap occupies exactly gap cycles of dds_en=0.
- Finite burst duration from first chirp_sync to done: count*max(len,1) + (count-1)*gap cycles, done in the cycle after the last SWEEP cycle.
- abort at edge N -> all outputs at reset values after edge N+1 (chirp_idx cleared).
- Asynchronous rst_n assertion mid-burst forces reset values immediately; deassertion returns to IDLE.

## Test plan
- Reset: rst_n=0 mid-SWEEP -> all outputs 0 immediately; after release, busy=0 until start.
- Single chirp: f0=0x1000_0000, step=0x100, len=4, gap=0, count=1 -> ftw 0x10000000,0x10000100,0x10000200,0x10000300 with dds_en=1; phase_clr/chirp_sync only on first; done pulse on next cycle; busy low the cycle after.
- Burst: len=3, gap=2, count=3 -> chirp_sync at cycles 0,5,10 relative to first; chirp_idx 0,1,2; done at cycle 13.
- Wrap/negative step: f0=0x0000_0010, step=0xFFFF_FFF0 (-16), len=3 -> ftw 0x10, 0x0, 0xFFFF_FFF0.
- Continuous + abort: count=0, len=2, gap=0 -> chirp_sync every 2 cycles for 600 cycles, chirp_idx wraps 255->0; abort -> IDLE next cycle, no done.
- Edge cases: len=0 -> 1-cycle chirps; start during SWEEP ignored; start and abort together in IDLE -> stays IDLE; cfg changed mid-burst -> no effect.
